// File: rtl/key_event_reader.sv
// Consumer of the sticky keypad bitmap: snapshots pressed keys, clears the latch
// and queues 4-bit key codes (lowest index first) into a small FWFT FIFO.
// Optional registered interrupt output when KEY_EVENT_IRQ_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for any bit of key_reg; snapshot it on entry to CLEAR
// S_CLEAR | key_clear high for one cycle; fold in coincident key pulses
// S_DRAIN | push lowest pending index per cycle, stall while FIFO is full
module key_event_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_NUM    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [KEY_NUM-1:0]            key_reg,
    input  logic [KEY_NUM-1:0]            key_pluse,
    output logic                          key_clear,
    input  logic                          rd_en,
    output logic [$clog2(KEY_NUM)-1:0]    key_code,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = $clog2(KEY_NUM);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [KEY_NUM-1:0]   r_pending;
    logic                 r_key_clear;
    logic [KW-1:0]        w_low_idx;

    logic [KW-1:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_valid;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_busy;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (key_reg != '0) w_next_state = S_CLEAR;
            S_CLEAR: w_next_state = S_DRAIN;
            S_DRAIN: if (r_pending == '0) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // output logic; a full FIFO still accepts a push when the head is popped in the same cycle
    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_pop  = rd_en && w_valid;
        w_push = (r_state == S_DRAIN) && (r_pending != '0) && (!w_full || rd_en);
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (r_pending[i]) w_low_idx = KW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_key_clear <= 1'b0;
        end else begin
            r_key_clear <= (r_state == S_IDLE) && (key_reg != '0);
            case (r_state)
                S_IDLE:  if (key_reg != '0) r_pending <= key_reg;
                // presses in the clear cycle are dropped by the latch, so keep them here
                S_CLEAR: r_pending <= r_pending | key_pluse;
                S_DRAIN: if (w_push) r_pending <= r_pending & (r_pending - 1'b1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_low_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == DEPTH_C);

    assign key_clear  = r_key_clear;
    assign key_valid  = w_valid;
    assign key_code   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign busy       = w_busy;

`ifdef KEY_EVENT_IRQ_EN
    logic r_irq;

    // follows FIFO occupancy one cycle late
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_valid;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule
